// File: rtl/reg_file_wb_sched.sv
// Write-back scheduler and busy scoreboard in front of a single-write-port reg_file.
// Round-robin arbitration between two write-back requesters, registered write port.
module reg_file_wb_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         issue_valid,
   input  logic [ADDR_WIDTH-1:0]        issue_rd,
   input  logic [ADDR_WIDTH-1:0]        issue_rs1,
   input  logic [ADDR_WIDTH-1:0]        issue_rs2,
   output logic                         hazard,
   input  logic                         wb0_valid,
   input  logic [ADDR_WIDTH-1:0]        wb0_rd,
   input  logic [DATA_WIDTH-1:0]        wb0_data,
   output logic                         wb0_ready,
   input  logic                         wb1_valid,
   input  logic [ADDR_WIDTH-1:0]        wb1_rd,
   input  logic [DATA_WIDTH-1:0]        wb1_data,
   output logic                         wb1_ready,
   output logic                         rf_wen,
   output logic [ADDR_WIDTH-1:0]        rf_waddr,
   output logic [DATA_WIDTH-1:0]        rf_wdata,
   output logic [(1<<ADDR_WIDTH)-1:0]   busy_vec,
   output logic                         wb_err
);

   localparam int NREG = 1 << ADDR_WIDTH;

   logic [NREG-1:0]       busy_q, busy_d;
   logic                  last_grant_q, last_grant_d;
   logic                  rf_wen_q, rf_wen_d;
   logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic                  wb_err_q, wb_err_d;

   logic                  issue_fire;
   logic                  grant0, grant1, grant_any;
   logic [ADDR_WIDTH-1:0] grant_rd;
   logic [DATA_WIDTH-1:0] grant_data;

   always_comb begin
      hazard     = issue_valid &
                   (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
      issue_fire = issue_valid & ~hazard;
   end

   // Under contention the requester that did not win last time gets the port.
   always_comb begin
      grant0     = wb0_valid & (~wb1_valid | last_grant_q);
      grant1     = wb1_valid & (~wb0_valid | ~last_grant_q);
      grant_any  = grant0 | grant1;
      grant_rd   = grant1 ? wb1_rd   : wb0_rd;
      grant_data = grant1 ? wb1_data : wb0_data;
      wb0_ready  = grant0;
      wb1_ready  = grant1;
   end

   always_comb begin
      last_grant_d = last_grant_q;
      rf_wen_d     = 1'b0;
      rf_waddr_d   = rf_waddr_q;
      rf_wdata_d   = rf_wdata_q;
      wb_err_d     = wb_err_q;
      if (grant_any) begin
         last_grant_d = grant1;
         rf_wen_d     = (grant_rd != '0);
         rf_waddr_d   = grant_rd;
         rf_wdata_d   = grant_data;
         if ((grant_rd != '0) && !busy_q[grant_rd]) begin
            wb_err_d = 1'b1;
         end
      end
   end

   // Clear lands on the same edge the reg_file commits; a same-edge set wins.
   always_comb begin
      busy_d = busy_q;
      if (rf_wen_q) begin
         busy_d[rf_waddr_q] = 1'b0;
      end
      if (issue_fire && (issue_rd != '0)) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         busy_q       <= '0;
         last_grant_q <= 1'b1;
         rf_wen_q     <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
         wb_err_q     <= 1'b0;
      end else begin
         busy_q       <= busy_d;
         last_grant_q <= last_grant_d;
         rf_wen_q     <= rf_wen_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
         wb_err_q     <= wb_err_d;
      end
   end

   always_comb begin
      rf_wen   = rf_wen_q;
      rf_waddr = rf_waddr_q;
      rf_wdata = rf_wdata_q;
      busy_vec = busy_q;
      wb_err   = wb_err_q;
   end

endmodule

// File: tb/tb_reg_file_wb_sched.sv
// Directed table-driven bench for reg_file_wb_sched: one row per clock cycle,
// combinational outputs checked against this row's inputs, registered outputs against the prior edge.
module tb_reg_file_wb_sched;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          resetn;
   logic          issue_valid;
   logic [AW-1:0] issue_rd, issue_rs1, issue_rs2;
   logic          hazard;
   logic          wb0_valid, wb1_valid;
   logic [AW-1:0] wb0_rd, wb1_rd;
   logic [DW-1:0] wb0_data, wb1_data;
   logic          wb0_ready, wb1_ready;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [31:0]   busy_vec;
   logic          wb_err;

   int total = 0;
   int bad   = 0;

   reg_file_wb_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .resetn(resetn),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .hazard(hazard),
      .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy_vec(busy_vec), .wb_err(wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rstn;
      logic          iv;
      logic [AW-1:0] ird, irs1, irs2;
      logic          v0;
      logic [AW-1:0] rd0;
      logic [DW-1:0] d0;
      logic          v1;
      logic [AW-1:0] rd1;
      logic [DW-1:0] d1;
      logic          e_haz, e_r0, e_r1, e_wen;
      logic [AW-1:0] e_waddr;
      logic [DW-1:0] e_wdata;
      logic [31:0]   e_busy;
      logic          e_err;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rstn, input logic iv, input int ird, input int irs1,
                      input int irs2, input logic v0, input int rd0, input logic [DW-1:0] d0,
                      input logic v1, input int rd1, input logic [DW-1:0] d1,
                      input logic e_haz, input logic e_r0, input logic e_r1, input logic e_wen,
                      input int e_waddr, input logic [DW-1:0] e_wdata,
                      input logic [31:0] e_busy, input logic e_err);
      vec_t v;
      v.rstn = rstn; v.iv = iv;
      v.ird = AW'(ird); v.irs1 = AW'(irs1); v.irs2 = AW'(irs2);
      v.v0 = v0; v.rd0 = AW'(rd0); v.d0 = d0;
      v.v1 = v1; v.rd1 = AW'(rd1); v.d1 = d1;
      v.e_haz = e_haz; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_wen = e_wen;
      v.e_waddr = AW'(e_waddr); v.e_wdata = e_wdata; v.e_busy = e_busy; v.e_err = e_err;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row=%0d got=0x%0h expected=0x%0h", name, row, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      resetn      = v.rstn;
      issue_valid = v.iv;  issue_rd = v.ird; issue_rs1 = v.irs1; issue_rs2 = v.irs2;
      wb0_valid   = v.v0;  wb0_rd   = v.rd0; wb0_data  = v.d0;
      wb1_valid   = v.v1;  wb1_rd   = v.rd1; wb1_data  = v.d1;
   endtask

   initial begin
      vec_t idle;
      int   wait_cnt;
      bit   dropped;

      idle = '{rstn: 1'b0, iv: 1'b0, ird: '0, irs1: '0, irs2: '0, v0: 1'b0, rd0: '0, d0: '0,
               v1: 1'b0, rd1: '0, d1: '0, e_haz: 1'b0, e_r0: 1'b0, e_r1: 1'b0, e_wen: 1'b0,
               e_waddr: '0, e_wdata: '0, e_busy: '0, e_err: 1'b0};
      drive(idle);

      //   rstn iv rd rs1 rs2  v0 rd0 d0            v1 rd1 d1        haz r0 r1 wen waddr wdata         busy          err
      add(1, 0, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0, 0,             32'h0,        0); // 1 reset state
      add(1, 1, 5, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0, 0,             32'h0,        0); // 2 issue rd5
      add(1, 1, 1, 5, 0,  0, 0, 0,             0, 0, 0,         1, 0, 0, 0, 0, 0,             32'h20,       0); // 3 RAW rs1
      add(1, 1, 1, 5, 0,  1, 5, 32'hDEADBEEF,  0, 0, 0,         1, 1, 0, 0, 0, 0,             32'h20,       0); // 4 wb0 grant
      add(1, 1, 1, 5, 0,  0, 0, 0,             0, 0, 0,         1, 0, 0, 1, 5, 32'hDEADBEEF,  32'h20,       0); // 5 write, still hazard
      add(1, 1, 1, 5, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 5, 32'hDEADBEEF,  32'h0,        0); // 6 cleared, fires rd1
      add(1, 1, 3, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 5, 32'hDEADBEEF,  32'h2,        0); // 7
      add(1, 1, 4, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 5, 32'hDEADBEEF,  32'hA,        0); // 8
      add(1, 0, 0, 0, 0,  1, 3, 32'h33,        1, 4, 32'h44,    0, 0, 1, 0, 5, 32'hDEADBEEF,  32'h1A,       0); // 9 last=0 -> wb1
      add(1, 0, 0, 0, 0,  1, 3, 32'h33,        0, 0, 0,         0, 1, 0, 1, 4, 32'h44,        32'h1A,       0); // 10
      add(1, 0, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 1, 3, 32'h33,        32'hA,        0); // 11
      add(1, 1, 3, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 3, 32'h33,        32'h2,        0); // 12
      add(1, 1, 4, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 3, 32'h33,        32'hA,        0); // 13
      add(1, 0, 0, 0, 0,  1, 3, 32'h300,       1, 4, 32'h400,   0, 0, 1, 0, 3, 32'h33,        32'h1A,       0); // 14 wb1
      add(1, 0, 0, 0, 0,  1, 3, 32'h300,       1, 1, 32'h111,   0, 1, 0, 1, 4, 32'h400,       32'h1A,       0); // 15 wb0 (alternate)
      add(1, 0, 0, 0, 0,  0, 0, 0,             1, 1, 32'h111,   0, 0, 1, 1, 3, 32'h300,       32'hA,        0); // 16
      add(1, 0, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 1, 1, 32'h111,       32'h2,        0); // 17
      add(1, 0, 0, 0, 0,  0, 0, 0,             1, 0, 32'h1234,  0, 0, 1, 0, 1, 32'h111,       32'h0,        0); // 18 rd0 write
      add(1, 0, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0, 32'h1234,      32'h0,        0); // 19 no wen
      add(1, 0, 0, 0, 0,  1, 7, 32'h77,        0, 0, 0,         0, 1, 0, 0, 0, 32'h1234,      32'h0,        0); // 20 not busy
      add(1, 0, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 1, 7, 32'h77,        32'h0,        1); // 21 err set
      add(1, 1, 9, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 7, 32'h77,        32'h0,        1); // 22
      add(1, 0, 0, 0, 0,  1, 9, 32'h99,        0, 0, 0,         0, 1, 0, 0, 7, 32'h77,        32'h200,      1); // 23
      add(0, 0, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 1, 9, 32'h99,        32'h200,      1); // 24 reset mid-write
      add(1, 0, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0, 0,             32'h0,        0); // 25 discarded
      add(1, 1, 3, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0, 0,             32'h0,        0); // 26
      add(1, 1, 4, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 0, 0,             32'h8,        0); // 27
      add(1, 0, 0, 0, 0,  1, 3, 32'hA,         1, 4, 32'hB,     0, 1, 0, 0, 0, 0,             32'h18,       0); // 28 wb0 first
      add(1, 0, 0, 0, 0,  0, 0, 0,             1, 4, 32'hB,     0, 0, 1, 1, 3, 32'hA,         32'h18,       0); // 29
      add(1, 0, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 1, 4, 32'hB,         32'h10,       0); // 30
      add(1, 0, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 4, 32'hB,         32'h0,        0); // 31
      add(1, 1, 2, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 4, 32'hB,         32'h0,        0); // 32
      add(1, 1, 8, 0, 2,  0, 0, 0,             0, 0, 0,         1, 0, 0, 0, 4, 32'hB,         32'h4,        0); // 33 RAW rs2
      add(1, 1, 2, 0, 0,  1, 2, 32'h22,        0, 0, 0,         1, 1, 0, 0, 4, 32'hB,         32'h4,        0); // 34 WAW
      add(1, 1, 2, 0, 0,  0, 0, 0,             0, 0, 0,         1, 0, 0, 1, 2, 32'h22,        32'h4,        0); // 35
      add(1, 1, 2, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 2, 32'h22,        32'h0,        0); // 36
      add(1, 0, 0, 0, 0,  1, 11, 32'hB1,       0, 0, 0,         0, 1, 0, 0, 2, 32'h22,        32'h4,        0); // 37
      add(1, 1, 11, 0, 0, 0, 0, 0,             0, 0, 0,         0, 0, 0, 1, 11, 32'hB1,       32'h4,        1); // 38 set+clear
      add(1, 1, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 11, 32'hB1,       32'h804,      1); // 39 rd0 issue
      add(1, 0, 0, 0, 0,  0, 0, 0,             0, 0, 0,         0, 0, 0, 0, 11, 32'hB1,       32'h804,      1); // 40

      repeat (2) @(posedge clk);
      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk);
         #1 drive(vq[i]);
         #1;
         chk("hazard",    i + 1, 32'(hazard),    32'(vq[i].e_haz));
         chk("wb0_ready", i + 1, 32'(wb0_ready), 32'(vq[i].e_r0));
         chk("wb1_ready", i + 1, 32'(wb1_ready), 32'(vq[i].e_r1));
         chk("rf_wen",    i + 1, 32'(rf_wen),    32'(vq[i].e_wen));
         chk("rf_waddr",  i + 1, 32'(rf_waddr),  32'(vq[i].e_waddr));
         chk("rf_wdata",  i + 1, rf_wdata,       vq[i].e_wdata);
         chk("busy_vec",  i + 1, busy_vec,       vq[i].e_busy);
         chk("wb_err",    i + 1, 32'(wb_err),    32'(vq[i].e_err));
      end

      // Hand sequence: hazard on a pending load must drop exactly two cycles after its grant.
      @(posedge clk); #1 drive(idle);
      @(posedge clk); #1 resetn = 1'b1; issue_valid = 1'b1; issue_rd = 5'd12;
      @(posedge clk); #1 issue_rd = 5'd0; issue_rs1 = 5'd12;
      wb1_valid = 1'b1; wb1_rd = 5'd12; wb1_data = 32'hC0FFEE;
      #1 chk("seq_grant", 100, 32'(wb1_ready), 32'd1);
      wait_cnt = 0;
      dropped  = 1'b0;
      while (!dropped && wait_cnt < 10) begin
         @(posedge clk); #1 wb1_valid = 1'b0;
         wait_cnt++;
         #1 dropped = !hazard;
         if (wait_cnt == 1) chk("seq_wdata", 101, rf_wdata, 32'hC0FFEE);
      end
      chk("seq_hazard_drop", 102, 32'(dropped), 32'd1);
      chk("seq_drop_cycles", 103, 32'(wait_cnt), 32'd2);
      #1 chk("seq_busy_after", 104, busy_vec, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
